// File: rtl/myproject_mul_arbiter.sv
// Round-robin arbiter sharing one exact signed multiplier among NUM_REQ requesters.
// Define MYPROJECT_MUL_ARB_PIPE_EN to add a registered operand stage (latency 2 instead of 1).
module myproject_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 26,
  parameter int ID_WIDTH   = 2
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]      req_a,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]      req_b,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic signed [DOUT_WIDTH-1:0]       res_data,
  output logic [ID_WIDTH-1:0]                res_id,
  output logic                               busy
);

  // Returns {found, index} of the first valid requester searching from p with wrap.
  function automatic logic [ID_WIDTH:0] f_rr_pick(input logic [NUM_REQ-1:0] v,
                                                  input logic [ID_WIDTH-1:0] p);
    logic [ID_WIDTH:0] res;
    logic [NUM_REQ-1:0] sh;
    int j;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sh = v >> j;
      if (sh[0]) res = {1'b1, ID_WIDTH'(j)};
    end
    return res;
  endfunction

  // Full-precision product; operands are sign-extended to the output width first.
  function automatic logic signed [DOUT_WIDTH-1:0] f_mul_exact(
      input logic signed [DIN0_WIDTH-1:0] a,
      input logic signed [DIN1_WIDTH-1:0] b);
    logic signed [DOUT_WIDTH-1:0] ax;
    logic signed [DOUT_WIDTH-1:0] bx;
    ax = {{(DOUT_WIDTH-DIN0_WIDTH){a[DIN0_WIDTH-1]}}, a};
    bx = {{(DOUT_WIDTH-DIN1_WIDTH){b[DIN1_WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  logic [ID_WIDTH-1:0]          r_ptr;
  logic [ID_WIDTH:0]            w_pick;
  logic                         w_grant_valid;
  logic [ID_WIDTH-1:0]          w_grant_idx;
  logic                         w_can_accept;
  logic                         w_xfer;
  logic signed [DIN0_WIDTH-1:0] w_a_p0;
  logic signed [DIN1_WIDTH-1:0] w_b_p0;

  logic                         w_load;
  logic signed [DIN0_WIDTH-1:0] w_mul_a;
  logic signed [DIN1_WIDTH-1:0] w_mul_b;
  logic [ID_WIDTH-1:0]          w_load_id;

  logic                         r_res_valid;
  logic signed [DOUT_WIDTH-1:0] r_res_data;
  logic [ID_WIDTH-1:0]          r_res_id;

  // ---- p0: arbitration and operand select ----
  assign w_pick        = f_rr_pick(req_valid, r_ptr);
  assign w_grant_valid = w_pick[ID_WIDTH];
  assign w_grant_idx   = w_pick[ID_WIDTH-1:0];
  assign w_xfer        = w_grant_valid & w_can_accept;

  always_comb begin
    w_a_p0    = '0;
    w_b_p0    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_WIDTH'(i)) begin
        w_a_p0       = req_a[i*DIN0_WIDTH +: DIN0_WIDTH];
        w_b_p0       = req_b[i*DIN1_WIDTH +: DIN1_WIDTH];
        req_ready[i] = w_xfer;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

`ifdef MYPROJECT_MUL_ARB_PIPE_EN
  logic                         r_vld_p1;
  logic signed [DIN0_WIDTH-1:0] r_a_p1;
  logic signed [DIN1_WIDTH-1:0] r_b_p1;
  logic [ID_WIDTH-1:0]          r_id_p1;
  logic                         w_adv_p1;

  // ---- p1: registered operands ----
  assign w_adv_p1     = r_vld_p1 & (~r_res_valid | res_ready);
  assign w_can_accept = ~ap_rst & (~r_vld_p1 | w_adv_p1);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_vld_p1 <= 1'b0;
    end else if (~r_vld_p1 | w_adv_p1) begin
      r_vld_p1 <= w_xfer;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_xfer) begin
      r_a_p1  <= w_a_p0;
      r_b_p1  <= w_b_p0;
      r_id_p1 <= w_grant_idx;
    end
  end

  assign w_load    = w_adv_p1;
  assign w_mul_a   = r_a_p1;
  assign w_mul_b   = r_b_p1;
  assign w_load_id = r_id_p1;
  assign busy      = r_vld_p1 | r_res_valid;
`else
  assign w_can_accept = ~ap_rst & (~r_res_valid | res_ready);
  assign w_load       = w_xfer;
  assign w_mul_a      = w_a_p0;
  assign w_mul_b      = w_b_p0;
  assign w_load_id    = w_grant_idx;
  assign busy         = r_res_valid;
`endif

  // ---- output stage: product register ----
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else if (w_load) begin
      r_res_valid <= 1'b1;
      r_res_data  <= f_mul_exact(w_mul_a, w_mul_b);
      r_res_id    <= w_load_id;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_myproject_mul_arbiter.sv
// Directed self-checking bench for myproject_mul_arbiter (4 requesters, 16x10 signed).
module tb_myproject_mul_arbiter;
`ifdef MYPROJECT_MUL_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               ap_clk;
  logic               ap_rst;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [63:0]        req_a;
  logic [39:0]        req_b;
  logic               res_valid;
  logic               res_ready;
  logic signed [25:0] res_data;
  logic [1:0]         res_id;
  logic               busy;

  int checks = 0;
  int errors = 0;

  // Rotation operands: a = 1000*(i+1), b = {3,-5,7,-9}
  logic signed [25:0] exp_rot [4];

  myproject_mul_arbiter #(
    .NUM_REQ(4), .DIN0_WIDTH(16), .DIN1_WIDTH(10), .DOUT_WIDTH(26), .ID_WIDTH(2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic set_op(input int i, input logic [15:0] a, input logic [9:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*10 +: 10] = b;
  endtask

  task automatic set_rot_ops;
    set_op(0, 16'd1000, 10'd3);
    set_op(1, 16'd2000, -10'sd5);
    set_op(2, 16'd3000, 10'd7);
    set_op(3, 16'd4000, -10'sd9);
  endtask

  task automatic test_reset;
    @(negedge ap_clk);
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (res_data !== 26'd0) begin errors++; $display("FAIL reset_res_data got %h want 0", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id got %0d want 0", res_id); end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    req_valid = 4'h0;
    ap_rst = 1'b0;
  endtask

  task automatic test_rotation;
    set_rot_ops();
    res_ready = 1'b1;
    for (int n = 0; n <= 7 + LAT; n++) begin
      @(negedge ap_clk);
      req_valid = (n < 8) ? 4'hF : 4'h0;
      #1;
      if (n < 8) begin
        checks++; if (req_ready !== 4'(1 << (n % 4))) begin errors++; $display("FAIL rot_grant n=%0d got %b want %b", n, req_ready, 4'(1 << (n % 4))); end
      end else begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rot_idle_ready n=%0d got %b want 0000", n, req_ready); end
      end
      if (n >= LAT) begin
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rot_valid n=%0d got %b want 1", n, res_valid); end
        checks++; if (res_id !== 2'((n - LAT) % 4)) begin errors++; $display("FAIL rot_id n=%0d got %0d want %0d", n, res_id, (n - LAT) % 4); end
        checks++; if (res_data !== exp_rot[(n - LAT) % 4]) begin errors++; $display("FAIL rot_data n=%0d got %0d want %0d", n, res_data, exp_rot[(n - LAT) % 4]); end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rot_latency n=%0d got %b want 0", n, res_valid); end
      end
      if (n >= 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rot_busy n=%0d got %b want 1", n, busy); end
      end
    end
    @(negedge ap_clk);
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rot_drain_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rot_drain_busy got %b want 0", busy); end
  endtask

  task automatic test_single_positive;
    set_op(0, 16'h7FFF, 10'h1FF);
    res_ready = 1'b1;
    @(negedge ap_clk);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL pos_ready got %b want 0001", req_ready); end
    for (int k = 1; k <= LAT; k++) begin
      @(negedge ap_clk);
      req_valid = 4'b0000;
      #1;
      if (k < LAT) begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL pos_early_valid k=%0d got %b want 0", k, res_valid); end
      end
    end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL pos_valid got %b want 1", res_valid); end
    checks++; if (res_data !== 26'h0FF7E01) begin errors++; $display("FAIL pos_data got %h want 0ff7e01", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL pos_id got %0d want 0", res_id); end
    @(negedge ap_clk);
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL pos_dup got %b want 0", res_valid); end
  endtask

  task automatic test_negative_extremes;
    set_op(2, 16'h8000, 10'h200);
    res_ready = 1'b1;
    @(negedge ap_clk);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL neg_ready got %b want 0100", req_ready); end
    for (int k = 1; k <= LAT; k++) begin
      @(negedge ap_clk);
      req_valid = 4'b0000;
      #1;
    end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL neg_valid got %b want 1", res_valid); end
    checks++; if (res_data !== 26'h1000000) begin errors++; $display("FAIL neg_data got %h want 1000000", res_data); end
    checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL neg_id got %0d want 2", res_id); end
    @(negedge ap_clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL neg_busy got %b want 0", busy); end
  endtask

  // Entered with ptr = 3 after the negative-extremes transfer from requester 2.
  task automatic test_pointer_skip;
    logic [3:0] vseq [3] = '{4'b1000, 4'b0010, 4'b0101};
    logic [3:0] rseq [3] = '{4'b1000, 4'b0010, 4'b0100};
    logic [1:0] iseq [3] = '{2'd3, 2'd1, 2'd2};
    res_ready = 1'b1;
    for (int n = 0; n <= 2 + LAT; n++) begin
      @(negedge ap_clk);
      req_valid = (n < 3) ? vseq[n] : 4'b0000;
      #1;
      if (n < 3) begin
        checks++; if (req_ready !== rseq[n]) begin errors++; $display("FAIL skip_grant n=%0d got %b want %b", n, req_ready, rseq[n]); end
      end
      if (n >= LAT) begin
        checks++; if (res_id !== iseq[n - LAT] || res_valid !== 1'b1) begin errors++; $display("FAIL skip_id n=%0d got %0d/%b want %0d/1", n, res_id, res_valid, iseq[n - LAT]); end
      end
    end
    @(negedge ap_clk);
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL skip_drain got %b want 0", res_valid); end
  endtask

  // Entered with ptr = 3, so acceptance order is 3,0,1,2,...
  task automatic test_backpressure;
    set_rot_ops();
    res_ready = 1'b0;
    @(negedge ap_clk);
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_first_grant got %b want 1000", req_ready); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge ap_clk);
      #1;
      if (k >= LAT) begin
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd3) begin errors++; $display("FAIL bp_hold k=%0d got %b/%0d want 1/3", k, res_valid, res_id); end
        checks++; if (res_data !== exp_rot[3]) begin errors++; $display("FAIL bp_hold_data k=%0d got %0d want %0d", k, res_data, exp_rot[3]); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_ready k=%0d got %b want 0000", k, req_ready); end
      end
    end
    for (int j = 0; j <= 5 + LAT; j++) begin
      @(negedge ap_clk);
      if (j == 6) req_valid = 4'h0;
      res_ready = 1'b1;
      #1;
      checks++; if (res_valid !== 1'b1 || res_id !== 2'((3 + j) % 4)) begin errors++; $display("FAIL bp_order j=%0d got %b/%0d want 1/%0d", j, res_valid, res_id, (3 + j) % 4); end
      checks++; if (res_data !== exp_rot[(3 + j) % 4]) begin errors++; $display("FAIL bp_data j=%0d got %0d want %0d", j, res_data, exp_rot[(3 + j) % 4]); end
    end
    @(negedge ap_clk);
    #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b/%b want 0/0", res_valid, busy); end
  endtask

  task automatic test_reset_mid;
    set_rot_ops();
    res_ready = 1'b0;
    @(negedge ap_clk);
    req_valid = 4'hF;
    @(negedge ap_clk);
    @(negedge ap_clk);
    #2;
    ap_rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready got %b want 0000", req_ready); end
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    res_ready = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_valid got %b want 0", res_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_rel_grant got %b want 0001", req_ready); end
    for (int k = 1; k <= LAT; k++) begin
      @(negedge ap_clk);
      req_valid = 4'h0;
      #1;
    end
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin errors++; $display("FAIL rst_first_result got %b/%0d want 1/0", res_valid, res_id); end
    checks++; if (res_data !== exp_rot[0]) begin errors++; $display("FAIL rst_first_data got %0d want %0d", res_data, exp_rot[0]); end
    @(negedge ap_clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_final_busy got %b want 0", busy); end
  endtask

  initial begin
    exp_rot   = '{26'sd3000, -26'sd10000, 26'sd21000, -26'sd36000};
    ap_rst    = 1'b1;
    req_valid = 4'h0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    test_reset();
    test_rotation();
    test_single_positive();
    test_negative_extremes();
    test_pointer_skip();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
